// File: rtl/serial_feeder_pkg.sv
// Shared types for the serial word feeder: FSM state encoding and counter sizing.
// Parity state exists only when SERIAL_FEEDER_PARITY_EN is defined.
package serial_feeder_pkg;

`ifdef SERIAL_FEEDER_PARITY_EN
  typedef enum logic [1:0] {
    StIdle   = 2'b00,
    StShift  = 2'b01,
    StParity = 2'b10
  } state_e;
`else
  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StShift = 2'b01
  } state_e;
`endif

  // Bit counter only ever holds 0..width-1.
  function automatic int unsigned cnt_w(input int unsigned width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/serial_word_feeder_if.sv
// Word-in / serial-out signal bundle of the serial word feeder.
// master = word producer side, slave = feeder side.
interface serial_word_feeder_if #(
  parameter int unsigned WIDTH = 8
);
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             shift_out;
  logic             bit_valid;
  logic             word_done;
  logic             busy;

  modport master (
    output in_valid, in_data,
    input  in_ready, shift_out, bit_valid, word_done, busy
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, shift_out, bit_valid, word_done, busy
  );
endinterface

// File: rtl/feeder_hold_buffer.sv
// One-word holding register in front of the shift register.
// Accepts when empty; drained by the FSM when it loads the shift register.
module feeder_hold_buffer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid_i,
  input  logic [WIDTH-1:0] in_data_i,
  input  logic             drain_i,
  output logic             in_ready_o,
  output logic             hold_full_o,
  output logic [WIDTH-1:0] hold_data_o
);

  logic             hold_full_d, hold_full_q;
  logic [WIDTH-1:0] hold_data_d, hold_data_q;
  logic             accept;

  assign accept = in_valid_i && !hold_full_q;

  // Drain requires a full buffer, so it can never coincide with an accept.
  always_comb begin
    hold_full_d = hold_full_q;
    hold_data_d = hold_data_q;
    if (drain_i) begin
      hold_full_d = 1'b0;
    end else if (accept) begin
      hold_full_d = 1'b1;
      hold_data_d = in_data_i;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_full_q <= 1'b0;
      hold_data_q <= '0;
    end else begin
      hold_full_q <= hold_full_d;
      hold_data_q <= hold_data_d;
    end
  end

  assign in_ready_o  = !hold_full_q;
  assign hold_full_o = hold_full_q;
  assign hold_data_o = hold_data_q;

endmodule

// File: rtl/serial_word_feeder.sv
// Double-buffered parallel-to-serial feeder for the serial pattern recognizer.
// Optional even-parity bit per word when SERIAL_FEEDER_PARITY_EN is defined.
module serial_word_feeder
  import serial_feeder_pkg::*;
#(
  parameter int unsigned WIDTH      = 8,
  parameter bit          LSB_FIRST  = 1'b0,
  parameter bit          IDLE_LEVEL = 1'b0
) (
  input  logic                 clk,
  input  logic                 reset,
  serial_word_feeder_if.slave  bus
);

  localparam int unsigned CNT_W = cnt_w(WIDTH);

  state_e           state_d, state_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic [WIDTH-1:0] shreg_d, shreg_q;
  logic             hold_full;
  logic [WIDTH-1:0] hold_data;
  logic             in_ready;
  logic             drain;
`ifdef SERIAL_FEEDER_PARITY_EN
  logic             parity_d, parity_q;
`endif

  feeder_hold_buffer #(
    .WIDTH (WIDTH)
  ) u_hold (
    .clk         (clk),
    .reset       (reset),
    .in_valid_i  (bus.in_valid),
    .in_data_i   (bus.in_data),
    .drain_i     (drain),
    .in_ready_o  (in_ready),
    .hold_full_o (hold_full),
    .hold_data_o (hold_data)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    drain   = 1'b0;
`ifdef SERIAL_FEEDER_PARITY_EN
    parity_d = parity_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (hold_full) drain = 1'b1;
      end
      StShift: begin
        shreg_d = LSB_FIRST ? {1'b0, shreg_q[WIDTH-1:1]} : {shreg_q[WIDTH-2:0], 1'b0};
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
`ifdef SERIAL_FEEDER_PARITY_EN
          state_d = StParity;
`else
          // Gapless reload straight from the last data bit.
          if (hold_full) drain = 1'b1;
          else           state_d = StIdle;
`endif
        end
      end
`ifdef SERIAL_FEEDER_PARITY_EN
      StParity: begin
        if (hold_full) drain = 1'b1;
        else           state_d = StIdle;
      end
`endif
      default: state_d = StIdle;
    endcase
    if (drain) begin
      shreg_d = hold_data;
      cnt_d   = CNT_W'(WIDTH - 1);
      state_d = StShift;
`ifdef SERIAL_FEEDER_PARITY_EN
      parity_d = ^hold_data;
`endif
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      shreg_q <= '0;
`ifdef SERIAL_FEEDER_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
`ifdef SERIAL_FEEDER_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  always_comb begin
    bus.shift_out = IDLE_LEVEL;
    bus.bit_valid = 1'b0;
    bus.word_done = 1'b0;
    unique case (state_q)
      StShift: begin
        bus.shift_out = LSB_FIRST ? shreg_q[0] : shreg_q[WIDTH-1];
        bus.bit_valid = 1'b1;
`ifndef SERIAL_FEEDER_PARITY_EN
        bus.word_done = (cnt_q == '0);
`endif
      end
`ifdef SERIAL_FEEDER_PARITY_EN
      StParity: begin
        bus.shift_out = parity_q;
        bus.bit_valid = 1'b1;
        bus.word_done = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  assign bus.in_ready = in_ready;
  assign bus.busy     = hold_full || (state_q != StIdle);

endmodule
